// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared definitions for the pattern scan controller.
//   - 2-bit state encodings (IDLE, SHIFT, REPORT, CLEAR) and the FSM enum
//   - hit_cnt_w(): width needed to count 0..w hits in one word
package pattern_scan_ctrl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;
  localparam logic [1:0] ST_CLEAR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SHIFT  = ST_SHIFT,
    REPORT = ST_REPORT,
    CLEAR  = ST_CLEAR
  } state_e;

  function automatic int hit_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/pattern_scan_piso.sv
// W-bit parallel-in serial-out shifter, MSB first.
//   clk, rst : clock, async active-high reset
//   load_i   : capture data_i, restart bit index at 0
//   data_i   : parallel word
//   shift_i  : advance one bit (ignored when load_i is high)
//   bit_o    : current serial bit (flop output)
//   last_o   : current bit is the final one of the word
module pattern_scan_piso #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         shift_i,
  output logic         bit_o,
  output logic         last_o
);
  localparam int IW = $clog2(W);

  logic [W-1:0]  sr_q;
  logic [IW-1:0] idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else if (load_i) begin
      sr_q  <= data_i;
      idx_q <= '0;
    end else if (shift_i) begin
      // zero fill: the register drains to 0 once a word is fully sent
      sr_q  <= {sr_q[W-2:0], 1'b0};
      idx_q <= idx_q + IW'(1);
    end
  end

  assign bit_o  = sr_q[W-1];
  assign last_o = (idx_q == IW'(W - 1));

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Sequencer for a single-bit 1011 Mealy detector: accepts W-bit words on a
// valid/ready handshake, streams them MSB first into the detector and counts
// hits per word and in total.
//   clk, rst       : clock, async active-high reset
//   word_i/word_valid_i/word_ready_o : word handshake
//   chain_i        : 1 = keep detector history across words, 0 = clear first
//   abort_i        : abandon current word (SHIFT/CLEAR only)
//   total_clr_i    : synchronous clear of total_hits_o (wins over a hit)
//   det_d_o/det_valid_o/det_clr_o : detector drive; det_pattern_i : its output
//   done_o         : one-cycle pulse per completed word
//   word_hits_o    : hits of last completed word
//   total_hits_o   : saturating running hit count
module pattern_scan_ctrl
  import pattern_scan_ctrl_pkg::*;
#(
  parameter  int W  = 8,
  parameter  int TW = 16,
  localparam int CW = hit_cnt_w(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  word_i,
  input  logic          word_valid_i,
  output logic          word_ready_o,
  input  logic          chain_i,
  input  logic          abort_i,
  input  logic          total_clr_i,
  output logic          det_d_o,
  output logic          det_valid_o,
  output logic          det_clr_o,
  input  logic          det_pattern_i,
  output logic          done_o,
  output logic [CW-1:0] word_hits_o,
  output logic [TW-1:0] total_hits_o
);

  state_e        state_q, state_d;
  logic          abort_q, abort_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] word_hits_q, word_hits_d;
  logic [TW-1:0] total_q, total_d;
  logic          ready_q, done_q, clr_q, valid_q;
  logic          load, shift, last, hit;

  pattern_scan_piso #(.W(W)) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .data_i  (word_i),
    .shift_i (shift),
    .bit_o   (det_d_o),
    .last_o  (last)
  );

  // valid_q is high exactly in SHIFT cycles, so this is a qualified hit
  assign hit = valid_q & det_pattern_i;

  always_comb begin
    state_d     = state_q;
    abort_d     = abort_q;
    cnt_d       = cnt_q;
    word_hits_d = word_hits_q;
    load        = 1'b0;
    shift       = 1'b0;
    case (state_q)
      IDLE: begin
        if (word_valid_i) begin
          load    = 1'b1;
          cnt_d   = '0;
          abort_d = 1'b0;
          state_d = chain_i ? SHIFT : CLEAR;
        end
      end
      CLEAR: begin
        // abort_q marks a clear that terminates the word rather than starting it
        if (abort_q) begin
          abort_d = 1'b0;
          state_d = IDLE;
        end else if (abort_i) begin
          abort_d = 1'b1;
          state_d = CLEAR;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (hit) cnt_d = cnt_q + CW'(1);
        if (abort_i) begin
          abort_d = 1'b1;
          state_d = CLEAR;
        end else if (last) begin
          word_hits_d = cnt_q + CW'(hit);
          state_d     = REPORT;
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    total_d = total_q;
    if (total_clr_i)
      total_d = '0;
    else if (hit && (total_q != {TW{1'b1}}))
      total_d = total_q + TW'(1);
  end

  // outputs are decoded from the next state so they line up with state_q
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      abort_q     <= 1'b0;
      cnt_q       <= '0;
      word_hits_q <= '0;
      total_q     <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      clr_q       <= 1'b1;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      abort_q     <= abort_d;
      cnt_q       <= cnt_d;
      word_hits_q <= word_hits_d;
      total_q     <= total_d;
      ready_q     <= (state_d == IDLE);
      done_q      <= (state_d == REPORT);
      clr_q       <= (state_d == CLEAR);
      valid_q     <= (state_d == SHIFT);
    end
  end

  assign word_ready_o = ready_q;
  assign done_o       = done_q;
  assign det_clr_o    = clr_q;
  assign det_valid_o  = valid_q;
  assign word_hits_o  = word_hits_q;
  assign total_hits_o = total_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl with a behavioural 1011 overlapping detector.
module tb_pattern_scan_ctrl;
  localparam int W  = 8;
  localparam int TW = 2;
  localparam int CW = $clog2(W + 1);
  localparam int TOT_MAX = (1 << TW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  word_i;
  logic          word_valid_i, word_ready_o, chain_i, abort_i, total_clr_i;
  logic          det_d_o, det_valid_o, det_clr_o, det_pattern;
  logic          done_o;
  logic [CW-1:0] word_hits_o;
  logic [TW-1:0] total_hits_o;

  always #5 clk = ~clk;

  pattern_scan_ctrl #(.W(W), .TW(TW)) dut (
    .clk           (clk),
    .rst           (rst),
    .word_i        (word_i),
    .word_valid_i  (word_valid_i),
    .word_ready_o  (word_ready_o),
    .chain_i       (chain_i),
    .abort_i       (abort_i),
    .total_clr_i   (total_clr_i),
    .det_d_o       (det_d_o),
    .det_valid_o   (det_valid_o),
    .det_clr_o     (det_clr_o),
    .det_pattern_i (det_pattern),
    .done_o        (done_o),
    .word_hits_o   (word_hits_o),
    .total_hits_o  (total_hits_o)
  );

  // 1011 overlapping Mealy detector. States: 0 none, 1 "1", 2 "10", 3 "101"
  function automatic logic [1:0] det_next(input logic [1:0] s, input logic b);
    case (s)
      2'd0:    return b ? 2'd1 : 2'd0;
      2'd1:    return b ? 2'd1 : 2'd2;
      2'd2:    return b ? 2'd3 : 2'd0;
      default: return b ? 2'd1 : 2'd2;
    endcase
  endfunction

  logic [1:0] dst_q;
  always @(posedge clk or posedge det_clr_o)
    if (det_clr_o)        dst_q <= 2'd0;
    else if (det_valid_o) dst_q <= det_next(dst_q, det_d_o);
  assign det_pattern = det_valid_o && (dst_q == 2'd3) && det_d_o;

  typedef struct packed {
    logic [W-1:0]  word;
    logic [CW-1:0] wh;
    logic [TW-1:0] tot;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // model state: detector history, running total, last reported word hits
  logic [1:0] m_st  = 2'd0;
  int         m_tot = 0;
  int         m_wh  = 0;

  // capture serial stream; compare on done_o
  logic [W-1:0] cap = '0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (det_valid_o) cap <= {cap[W-2:0], det_d_o};
    if (done_o) begin
      if (sb.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        chk("serial_bits", cap, e.word);
        chk("word_hits", word_hits_o, e.wh);
        chk("total_hits", total_hits_o, e.tot);
      end
    end
  end

  // mode 0: normal, 1: abort on 4th SHIFT cycle, 2: total_clr on first hit,
  // 3: reset on 3rd SHIFT cycle
  task automatic send(input logic [W-1:0] word, input bit chain, input int mode);
    int   cyc, nb, whits, ss;
    bit   got, clr_done;
    logic b, h;
    nb = (mode == 1) ? 4 : (mode == 3) ? 0 : W;
    if (!chain) m_st = 2'd0;
    whits = 0; clr_done = 0;
    for (int i = 0; i < nb; i++) begin
      b = word[W-1-i];
      h = (m_st == 2'd3) && b;
      m_st = det_next(m_st, b);
      if (h) begin
        whits++;
        if (mode == 2 && !clr_done) begin m_tot = 0; clr_done = 1; end
        else if (m_tot < TOT_MAX) m_tot++;
      end
    end
    if (mode == 1) m_st = 2'd0;
    if (mode == 0 || mode == 2) begin
      sb.push_back('{word: word, wh: CW'(whits), tot: TW'(m_tot)});
      m_wh = whits;
    end
    clr_done = 0;

    cyc = 0;
    while (!word_ready_o && cyc < 40) begin @(negedge clk); cyc++; end
    chk("ready_wait", word_ready_o, 1);
    word_i = word; chain_i = chain; word_valid_i = 1'b1;
    @(negedge clk);                      // first cycle after the accept edge
    word_valid_i = 1'b0;
    word_i = ~word;
    chk("clr_pulse", det_clr_o, !chain);
    chk("busy_ready", word_ready_o, 0);
    cyc = 1;
    ss  = chain ? 1 : 2;                 // cycle index of the first SHIFT cycle
    case (mode)
      1: begin
        while (cyc < ss + 3) begin @(negedge clk); cyc++; end
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_clr", det_clr_o, 1);
        chk("abort_valid", det_valid_o, 0);
        chk("abort_nodone", done_o, 0);
        @(negedge clk);
        chk("abort_ready", word_ready_o, 1);
        chk("abort_nodone2", done_o, 0);
        chk("abort_total", total_hits_o, m_tot);
        chk("abort_wordhits", word_hits_o, m_wh);
      end
      3: begin
        while (cyc < ss + 2) begin @(negedge clk); cyc++; end
        #2 rst = 1'b1;
        #1;
        chk("rst_ready", word_ready_o, 1);
        chk("rst_valid", det_valid_o, 0);
        chk("rst_d", det_d_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_wordhits", word_hits_o, 0);
        chk("rst_total", total_hits_o, 0);
        chk("rst_clr", det_clr_o, 1);
        @(negedge clk);
        rst = 1'b0;
        m_st = 2'd0; m_tot = 0; m_wh = 0;
        @(negedge clk);
        chk("rst_clr_release", det_clr_o, 0);
      end
      default: begin
        got = 0;
        while (cyc < 30 && !got) begin
          if (mode == 2 && det_pattern && !clr_done) begin
            total_clr_i = 1'b1; clr_done = 1;
          end
          if (done_o) got = 1;
          else begin @(negedge clk); total_clr_i = 1'b0; cyc++; end
        end
        chk("done_latency", cyc, chain ? 9 : 10);
        if (mode == 2) chk("clr_on_hit_seen", clr_done, 1);
      end
    endcase
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; word_i = '0; word_valid_i = 0; chain_i = 0; abort_i = 0; total_clr_i = 0;
    repeat (2) @(negedge clk);
    chk("reset_ready", word_ready_o, 1);
    chk("reset_valid", det_valid_o, 0);
    chk("reset_d", det_d_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_wordhits", word_hits_o, 0);
    chk("reset_total", total_hits_o, 0);
    chk("reset_clr", det_clr_o, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("clr_after_release", det_clr_o, 0);

    // isolated word then chained word with a cross-boundary hit
    send(8'b10110110, 0, 0);
    send(8'hC0, 1, 0);

    // clear total, repeat with isolated second word
    @(negedge clk); total_clr_i = 1'b1;
    @(negedge clk); total_clr_i = 1'b0; m_tot = 0;
    chk("total_clr_idle", total_hits_o, 0);
    send(8'b10110110, 0, 0);
    send(8'hC0, 0, 0);

    // abort after the first hit of 10111011
    send(8'b10111011, 0, 1);

    // total is now saturated at 3; another hit must not wrap
    send(8'hB0, 0, 0);
    chk("sat_total", total_hits_o, TOT_MAX);
    // clear coincident with a hit drops that hit
    send(8'hB0, 0, 2);

    // reset mid-word, then a normal word
    send(8'b10110110, 0, 3);
    send(8'b10110110, 1, 0);

    for (int i = 0; i < 6; i++) send(W'($urandom), 1'($urandom_range(0, 1)), 0);

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
